// File: rtl/l15_req_port_arbiter.sv
// l15_req_port_arbiter
//   N-port request arbiter feeding the L1.5 request channel. Merges the
//   I$, D$ miss, wbuf, uncached and AMO request streams into one registered
//   request tagged with its source port id.
//   ArbMode=0 selects fixed priority (port 0 highest) with anti-starvation
//   aging; ArbMode=1 selects round-robin. No grant is issued until the
//   post-reset wake-up count has expired.
//
// Ports
//   clk_i         in   clock
//   reset_l       in   asynchronous reset, active-low
//   req_valid_i   in   per-port request valid
//   req_ready_o   out  per-port accept (one-hot or zero)
//   req_data_i    in   per-port payload, port p at [p*PayloadWidth +: PayloadWidth]
//   out_valid_o   out  registered request valid toward L1.5
//   out_ready_i   in   L1.5 accepts the held request
//   out_data_o    out  registered payload
//   out_portid_o  out  source port of out_data_o
//   wake_done_o   out  wake-up period elapsed
module l15_req_port_arbiter #(
  parameter int NumPorts     = 6,
  parameter int PayloadWidth = 128,
  parameter int ArbMode      = 0,
  parameter int StarveTh     = 16,
  parameter int WakeUpCycles = 32768
) (
  input  logic                             clk_i,
  input  logic                             reset_l,
  input  logic [NumPorts-1:0]              req_valid_i,
  output logic [NumPorts-1:0]              req_ready_o,
  input  logic [NumPorts*PayloadWidth-1:0] req_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [PayloadWidth-1:0]          out_data_o,
  output logic [$clog2(NumPorts)-1:0]      out_portid_o,
  output logic                             wake_done_o
);

  localparam int IdW   = $clog2(NumPorts);
  localparam int IdxW  = IdW + 1;
  localparam int WakeW = $clog2(WakeUpCycles + 1);

  // Wake-up gate
  logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;
  logic             wake_done_q, wake_done_d;

  assign wake_cnt_d  = (wake_cnt_q == WakeW'(WakeUpCycles)) ? wake_cnt_q
                                                            : wake_cnt_q + WakeW'(1);
  // Registered one cycle behind the count reaching its terminal value.
  assign wake_done_d = (wake_cnt_q == WakeW'(WakeUpCycles));

  // Output slot and grant
  logic                    out_valid_q, out_valid_d;
  logic [PayloadWidth-1:0] out_data_q, out_data_d;
  logic [IdW-1:0]          out_portid_q, out_portid_d;
  logic                    slot_free, any_valid, accept;
  logic [IdW-1:0]          grant_id;

  assign any_valid   = |req_valid_i;
  // A held request leaving this cycle frees the slot for a same-cycle refill.
  assign slot_free   = !out_valid_q || out_ready_i;
  assign accept      = wake_done_q && slot_free && any_valid;
  assign req_ready_o = accept ? (NumPorts'(1) << grant_id) : '0;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_portid_d = out_portid_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = req_data_i[grant_id*PayloadWidth +: PayloadWidth];
      out_portid_d = grant_id;
    end else if (out_ready_i) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      wake_cnt_q   <= '0;
      wake_done_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_portid_q <= '0;
    end else begin
      wake_cnt_q   <= wake_cnt_d;
      wake_done_q  <= wake_done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_portid_q <= out_portid_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_portid_o = out_portid_q;
  assign wake_done_o  = wake_done_q;

  // Winner selection
  if (ArbMode == 0) begin : g_fixed
    localparam int AgeW = $clog2(StarveTh + 1);
    logic [NumPorts-1:0] promoted;
    logic                found;

    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_age
      logic [AgeW-1:0] age_q, age_d;

      // Ages keep growing under backpressure; only a grant, a dropped
      // valid, or the wake gate clears them.
      always_comb begin
        age_d = age_q;
        if (!wake_done_q || !req_valid_i[gi] || (accept && grant_id == IdW'(gi))) begin
          age_d = '0;
        end else if (age_q != AgeW'(StarveTh)) begin
          age_d = age_q + AgeW'(1);
        end
      end

      always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
          age_q <= '0;
        end else begin
          age_q <= age_d;
        end
      end

      assign promoted[gi] = req_valid_i[gi] && (age_q == AgeW'(StarveTh));
    end

    // Lowest promoted port first, otherwise lowest valid port.
    always_comb begin
      grant_id = '0;
      found    = 1'b0;
      for (int i = 0; i < NumPorts; i++) begin
        if (!found && promoted[i]) begin
          found    = 1'b1;
          grant_id = IdW'(i);
        end
      end
      for (int i = 0; i < NumPorts; i++) begin
        if (!found && req_valid_i[i]) begin
          found    = 1'b1;
          grant_id = IdW'(i);
        end
      end
    end
  end else if (ArbMode == 1) begin : g_rr
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [IdxW-1:0] rr_idx;
    logic            found;

    // Scan from the pointer, wrapping modulo NumPorts.
    always_comb begin
      grant_id = '0;
      found    = 1'b0;
      rr_idx   = '0;
      for (int i = 0; i < NumPorts; i++) begin
        rr_idx = {1'b0, ptr_q} + IdxW'(i);
        if (rr_idx >= IdxW'(NumPorts)) begin
          rr_idx = rr_idx - IdxW'(NumPorts);
        end
        if (!found && req_valid_i[rr_idx[IdW-1:0]]) begin
          found    = 1'b1;
          grant_id = rr_idx[IdW-1:0];
        end
      end
    end

    always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
        ptr_d = (grant_id == IdW'(NumPorts - 1)) ? '0 : grant_id + IdW'(1);
      end
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end
  end else begin : g_bad_mode
    $error("l15_req_port_arbiter: ArbMode must be 0 or 1");
    assign grant_id = '0;
  end

endmodule

// File: tb/tb_l15_req_port_arbiter.sv
// Directed bench for l15_req_port_arbiter. Two instances share one clock:
// a fixed-priority instance (StarveTh=3) and a round-robin instance. Each
// has a behavioural model that predicts grants and held outputs every cycle;
// directed phases add literal expectations on grant order and timing.
module tb_l15_req_port_arbiter;

  localparam int N   = 6;
  localparam int PW  = 32;
  localparam int W   = 4;
  localparam int TH  = 3;
  localparam int IdW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_l;
  logic [N-1:0]    valid     [2];
  logic [N-1:0]    ready     [2];
  logic [N*PW-1:0] data      [2];
  logic            out_valid [2];
  logic            out_ready [2];
  logic [PW-1:0]   out_data  [2];
  logic [IdW-1:0]  out_pid   [2];
  logic            wake      [2];

  int n_checks = 0;
  int n_fail   = 0;

  l15_req_port_arbiter #(.NumPorts(N), .PayloadWidth(PW), .ArbMode(0),
                         .StarveTh(TH), .WakeUpCycles(W)) u_fixed (
    .clk_i(clk), .reset_l(rst_l[0]),
    .req_valid_i(valid[0]), .req_ready_o(ready[0]), .req_data_i(data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_data_o(out_data[0]), .out_portid_o(out_pid[0]), .wake_done_o(wake[0]));

  l15_req_port_arbiter #(.NumPorts(N), .PayloadWidth(PW), .ArbMode(1),
                         .StarveTh(TH), .WakeUpCycles(W)) u_rr (
    .clk_i(clk), .reset_l(rst_l[1]),
    .req_valid_i(valid[1]), .req_ready_o(ready[1]), .req_data_i(data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_data_o(out_data[1]), .out_portid_o(out_pid[1]), .wake_done_o(wake[1]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Fresh payloads every cycle so a wrong payload mux shows up.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < N; p++)
        data[k][p*PW +: PW] <= $urandom;
  end

  // Behavioural models: gi=0 fixed priority with aging, gi=1 round-robin.
  for (genvar gi = 0; gi < 2; gi++) begin : g_model
    int            cyc;        // clock edges since reset release (saturating)
    bit            m_valid;
    logic [PW-1:0] m_data;
    int            m_pid;
    int            rr_next;
    int            wait_c [N]; // cycles each port has waited unserved

    function automatic int pick();
      if (!rst_l[gi] || cyc <= W) return -1;
      if (m_valid && !out_ready[gi]) return -1;
      if (gi == 0) begin
        for (int p = 0; p < N; p++) if (valid[gi][p] && wait_c[p] >= TH) return p;
        for (int p = 0; p < N; p++) if (valid[gi][p]) return p;
      end else begin
        for (int k = 0; k < N; k++) if (valid[gi][(rr_next + k) % N]) return (rr_next + k) % N;
      end
      return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
      int w;
      w = pick();
      if (w < 0) return '0;
      return N'(1) << w;
    endfunction

    function automatic logic [PW-1:0] payload(int p);
      return data[gi][p*PW +: PW];
    endfunction

    function automatic int next_wait(int p);
      if (cyc <= W || !valid[gi][p] || pick() == p) return 0;
      return (wait_c[p] >= TH) ? TH : wait_c[p] + 1;
    endfunction

    always @(posedge clk or negedge rst_l[gi]) begin
      if (!rst_l[gi]) begin
        cyc     <= 0;
        m_valid <= 1'b0;
        m_data  <= '0;
        m_pid   <= 0;
        rr_next <= 0;
        for (int p = 0; p < N; p++) wait_c[p] <= 0;
      end else begin
        if (cyc <= W) cyc <= cyc + 1;
        if (pick() >= 0) begin
          m_valid <= 1'b1;
          m_data  <= payload(pick());
          m_pid   <= pick();
          rr_next <= (pick() + 1) % N;
        end else if (out_ready[gi]) begin
          m_valid <= 1'b0;
        end
        for (int p = 0; p < N; p++) wait_c[p] <= next_wait(p);
      end
    end

    always @(negedge clk) begin
      check("model_ready", ready[gi], exp_ready());
      check("model_out_valid", out_valid[gi], m_valid);
      check("model_wake", wake[gi], rst_l[gi] && cyc > W);
      if (m_valid || !rst_l[gi]) begin
        check("model_out_data", out_data[gi], m_data);
        check("model_out_portid", out_pid[gi], m_pid);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0]  exp_fp [4] = '{6'b000010, 6'b000010, 6'b000010, 6'b001000};
  logic [N-1:0]  exp_ag [5] = '{6'b000001, 6'b000001, 6'b000001, 6'b000100, 6'b000001};
  logic [N-1:0]  exp_pr [3] = '{6'b000100, 6'b100000, 6'b000100};
  logic [PW-1:0] held_a;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_l        = 2'b00;
    valid[0]     = '0;
    valid[1]     = '0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_l    = 2'b11;
    valid[0] = '1;

    // Wake gate: nothing granted for cycles 0..W, port 0 wins at cycle W+1.
    for (int c = 0; c <= W; c++) begin
      @(negedge clk);
      check("wake_gate_ready", ready[0], '0);
      step();
    end
    @(negedge clk);
    check("first_grant", ready[0], 6'b000001);
    check("first_wake", wake[0], 1'b1);
    $display("wake: first grant ready=%b", ready[0]);
    step();

    // Fixed priority among ports 1 and 3 (port 3 promoted on its 4th wait).
    valid[0] = '0;
    step();
    valid[0] = 6'b001010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fixed_prio_grant", ready[0], exp_fp[i]);
      if (i > 0) check("fixed_prio_portid", out_pid[0], 3'd1);
      $display("fixed: arb %0d ready=%b portid=%0d", i, ready[0], out_pid[0]);
      step();
    end

    // Aging: ports 0 and 2, port 2 promoted on the 4th arbitration.
    valid[0] = '0;
    step();
    valid[0] = 6'b000101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("aging_grant", ready[0], exp_ag[i]);
      $display("aging: arb %0d ready=%b", i, ready[0]);
      step();
    end

    // Backpressure: A held for 5 cycles, then released with same-cycle refill.
    valid[0] = '0;
    step();
    valid[0] = 6'b000001;
    @(negedge clk);
    check("bp_accept_a", ready[0], 6'b000001);
    held_a = data[0][PW-1:0];
    step();
    out_ready[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_data", out_data[0], held_a);
      check("bp_hold_valid", out_valid[0], 1'b1);
      check("bp_no_ready", ready[0], '0);
      step();
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_grant", ready[0], 6'b000001);
    check("bp_release_data", out_data[0], held_a);
    $display("backpressure: released A=%h ready=%b", held_a, ready[0]);
    step();

    // Reset mid-operation with a request held.
    out_ready[0] = 1'b0;
    @(negedge clk);
    check("midrst_pre_valid", out_valid[0], 1'b1);
    #2;
    rst_l[0] = 1'b0;
    #1;
    check("midrst_async_valid", out_valid[0], 1'b0);
    check("midrst_async_wake", wake[0], 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_l[0]     = 1'b1;
    out_ready[0] = 1'b1;
    for (int c = 0; c <= W; c++) begin
      @(negedge clk);
      check("midrst_wake_low", wake[0], 1'b0);
      check("midrst_no_ready", ready[0], '0);
      step();
    end
    @(negedge clk);
    check("midrst_wake_high", wake[0], 1'b1);
    check("midrst_grant", ready[0], 6'b000001);
    $display("reset: regrant ready=%b", ready[0]);
    valid[0] = '0;
    step();

    // Round-robin: all ports valid, order 0..5 then wrap to 0.
    valid[1] = '1;
    for (int i = 0; i < 7; i++) begin
      logic [N-1:0] exp_oh;
      exp_oh = N'(1) << (i % N);
      @(negedge clk);
      check("rr_grant", ready[1], exp_oh);
      $display("rr: arb %0d ready=%b", i, ready[1]);
      step();
    end
    // Pointer now at 1: sparse requesters 2 and 5.
    valid[1] = 6'b100100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rr_sparse_grant", ready[1], exp_pr[i]);
      $display("rr: sparse arb %0d ready=%b", i, ready[1]);
      step();
    end

    // Mixed traffic and backpressure, checked by the models only.
    for (int c = 0; c < 40; c++) begin
      valid[0]     = N'($urandom);
      valid[1]     = N'($urandom);
      out_ready[0] = 1'($urandom_range(0, 1));
      out_ready[1] = 1'($urandom_range(0, 1));
      step();
    end
    valid[0]     = '0;
    valid[1]     = '0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    step();
    step();
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
